// File: rtl/riscv_div_pkg.sv
// riscv_div_pkg -- shared definitions for the divider request controller.
//   UDIV/DIV/UREM/REM : opcode encodings on ReqOp_SI / DivOpCode_SO
//   divState_e        : controller FSM state encoding
package riscv_div_pkg;

  localparam logic [1:0] UDIV = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] UREM = 2'd2;
  localparam logic [1:0] REM  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } divState_e;

endpackage

// File: rtl/riscv_div_lzc.sv
// riscv_div_lzc -- leading-zero counter.
//   In_DI  [C_WIDTH]     : vector to scan from the MSB down
//   Cnt_DO [C_LOG_WIDTH] : number of leading zeros; an all-zero input gives C_WIDTH
// Leading ones are counted by feeding the inverted vector.
module riscv_div_lzc #(
  parameter int C_WIDTH     = 32,
  parameter int C_LOG_WIDTH = 6
) (
  input  logic [C_WIDTH-1:0]     In_DI,
  output logic [C_LOG_WIDTH-1:0] Cnt_DO
);

  // Scanning upward lets the highest set bit write last and win.
  always_comb begin
    Cnt_DO = C_LOG_WIDTH'(C_WIDTH);
    for (int i = 0; i < C_WIDTH; i++) begin
      if (In_DI[i]) Cnt_DO = C_LOG_WIDTH'(C_WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/riscv_div_ctrl.sv
// riscv_div_ctrl -- request/response controller in front of a serial divider.
// Accepts one divide/remainder request, normalises the divisor, hands the
// operands to the divider for one cycle, waits for its result and holds the
// result until the response handshake completes.
//   Clk_CI, Rst_RI                    : clock, synchronous active-high reset
//   ReqVld_SI/ReqRdy_SO               : request handshake (accepted only in IDLE)
//   ReqOpA_DI, ReqOpB_DI, ReqOp_SI    : dividend, divisor, opcode (UDIV/DIV/UREM/REM)
//   RspVld_SO/RspRdy_SI, RspRes_DO    : response handshake and result
//   DivOp*_DO/_SO, DivInVld_SO        : registered operands and start strobe to the divider
//   DivOutVld_SI, DivRes_DI, DivOutRdy_SO : divider result handshake
//   Busy_SO                           : high whenever the FSM is not IDLE
// Optional build macro RISCV_DIV_FASTZERO_EN: a zero divisor bypasses the
// divider and the architectural result is returned one cycle after accept.
module riscv_div_ctrl
  import riscv_div_pkg::*;
#(
  parameter int C_WIDTH     = 32,
  parameter int C_LOG_WIDTH = 6
) (
  input  logic                   Clk_CI,
  input  logic                   Rst_RI,
  input  logic                   ReqVld_SI,
  output logic                   ReqRdy_SO,
  input  logic [C_WIDTH-1:0]     ReqOpA_DI,
  input  logic [C_WIDTH-1:0]     ReqOpB_DI,
  input  logic [1:0]             ReqOp_SI,
  output logic                   RspVld_SO,
  input  logic                   RspRdy_SI,
  output logic [C_WIDTH-1:0]     RspRes_DO,
  output logic [C_WIDTH-1:0]     DivOpA_DO,
  output logic [C_WIDTH-1:0]     DivOpB_DO,
  output logic [C_LOG_WIDTH-1:0] DivOpBShift_DO,
  output logic                   DivOpBIsZero_SO,
  output logic                   DivOpBSign_SO,
  output logic [1:0]             DivOpCode_SO,
  output logic                   DivInVld_SO,
  output logic                   DivOutRdy_SO,
  input  logic                   DivOutVld_SI,
  input  logic [C_WIDTH-1:0]     DivRes_DI,
  output logic                   Busy_SO
);

  divState_e              stateDP, stateDN;
  logic                   accept;
  logic                   opBSign;
  logic                   opBIsZero;
  logic                   fastZero;
  logic [C_WIDTH-1:0]     lzcIn;
  logic [C_WIDTH-1:0]     opBShifted;
  logic [C_LOG_WIDTH-1:0] opBShift;

  // Result of a division by zero when the divider is bypassed.
  function automatic logic [C_WIDTH-1:0] fastZeroRes(input logic [1:0]         op,
                                                    input logic [C_WIDTH-1:0] a);
    case (op)
      UDIV, DIV: fastZeroRes = '1;
      UREM, REM: fastZeroRes = a;
      default:   fastZeroRes = a;
    endcase
  endfunction

  assign accept    = (stateDP == IDLE) & ReqVld_SI;
  // Only the signed opcodes (odd encodings) treat a set MSB as negative.
  assign opBSign   = ReqOpB_DI[C_WIDTH-1] & ReqOp_SI[0];
  assign opBIsZero = (ReqOpB_DI == '0);
  // Negative divisors are normalised on their leading ones.
  assign lzcIn     = opBSign ? ~ReqOpB_DI : ReqOpB_DI;

  riscv_div_lzc #(
    .C_WIDTH     (C_WIDTH),
    .C_LOG_WIDTH (C_LOG_WIDTH)
  ) i_lzc (
    .In_DI  (lzcIn),
    .Cnt_DO (opBShift)
  );

  // A shift of C_WIDTH (zero divisor, or -1 signed) shifts everything out.
  assign opBShifted = ReqOpB_DI << opBShift;

`ifdef RISCV_DIV_FASTZERO_EN
  assign fastZero = opBIsZero;
`else
  assign fastZero = 1'b0;
`endif

  // State register
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) stateDP <= IDLE;
    else        stateDP <= stateDN;
  end

  // Next-state logic; requests arriving outside IDLE are simply not seen.
  always_comb begin
    stateDN = stateDP;
    case (stateDP)
      IDLE:    if (ReqVld_SI) stateDN = fastZero ? RESP : ISSUE;
      ISSUE:   stateDN = WAIT;
      WAIT:    if (DivOutVld_SI) stateDN = RESP;
      RESP:    if (RspRdy_SI) stateDN = IDLE;
      default: stateDN = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    ReqRdy_SO    = 1'b0;
    RspVld_SO    = 1'b0;
    DivInVld_SO  = 1'b0;
    DivOutRdy_SO = 1'b0;
    Busy_SO      = 1'b1;
    case (stateDP)
      IDLE: begin
        ReqRdy_SO = 1'b1;
        Busy_SO   = 1'b0;
      end
      ISSUE:   DivInVld_SO  = 1'b1;
      WAIT:    DivOutRdy_SO = 1'b1;
      RESP:    RspVld_SO    = 1'b1;
      default: ;
    endcase
  end

  // Operand and result registers
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      DivOpA_DO       <= '0;
      DivOpB_DO       <= '0;
      DivOpBShift_DO  <= '0;
      DivOpBIsZero_SO <= 1'b0;
      DivOpBSign_SO   <= 1'b0;
      DivOpCode_SO    <= '0;
      RspRes_DO       <= '0;
    end else begin
      if (accept && !fastZero) begin
        DivOpA_DO       <= ReqOpA_DI;
        DivOpB_DO       <= opBShifted;
        DivOpBShift_DO  <= opBShift;
        DivOpBIsZero_SO <= opBIsZero;
        DivOpBSign_SO   <= opBSign;
        DivOpCode_SO    <= ReqOp_SI;
      end
      // DivOutVld_SI only counts while waiting, never in the ISSUE cycle.
      if (accept && fastZero)
        RspRes_DO <= fastZeroRes(ReqOp_SI, ReqOpA_DI);
      else if ((stateDP == WAIT) && DivOutVld_SI)
        RspRes_DO <= DivRes_DI;
    end
  end

endmodule

// File: doc/riscv_div_ctrl.md
RISCV_DIV_CTRL -- requirements
Module: riscv_div_ctrl

Interface
REQ-001 SHALL have parameter C_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter C_LOG_WIDTH, default 6, shift-count width; it equals clog2(C_WIDTH+1).
REQ-003 SHALL have Clk_CI  in  1  sole clock, rising edge.
REQ-004 SHALL have Rst_RI  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ReqVld_SI in 1, ReqRdy_SO out 1: request handshake.
REQ-006 SHALL have ReqOpA_DI in C_WIDTH, ReqOpB_DI in C_WIDTH: dividend, divisor.
REQ-007 SHALL have ReqOp_SI in 2: 0 udiv, 1 div, 2 urem, 3 rem.
REQ-008 SHALL have RspVld_SO out 1, RspRdy_SI in 1, RspRes_DO out C_WIDTH: response handshake and result.
REQ-009 SHALL have divider-side outputs DivOpA_DO C_WIDTH, DivOpB_DO C_WIDTH, DivOpBShift_DO C_LOG_WIDTH, DivOpBIsZero_SO 1, DivOpBSign_SO 1, DivOpCode_SO 2, DivInVld_SO 1, DivOutRdy_SO 1.
REQ-010 SHALL have divider-side inputs DivOutVld_SI 1, DivRes_DI C_WIDTH.
REQ-011 SHALL have Busy_SO out 1: high whenever state is not IDLE.

Function
REQ-012 SHALL implement FSM IDLE, ISSUE, WAIT, RESP.
REQ-013 IDLE: ReqRdy_SO=1; on ReqVld_SI register A, B, opcode and go to ISSUE.
REQ-014 Operand prep (registered at accept): sign = B[MSB] & ReqOp_SI[0]; shift = clz(B) if sign=0, count of leading ones of B if sign=1; B==0 gives shift=C_WIDTH and IsZero=1; DivOpB_DO = B << shift (bits shifted out discarded).
REQ-015 ISSUE: DivInVld_SO=1 for exactly one cycle, then WAIT; the divider is idle here by construction.
REQ-016 WAIT: DivOutRdy_SO=1; DivOutVld_SI is ignored in the ISSUE cycle; first DivOutVld_SI=1 in WAIT captures DivRes_DI into the result register, then RESP.
REQ-017 RESP: RspVld_SO=1, RspRes_DO stable; on RspRdy_SI go to IDLE; ReqRdy_SO=0 in RESP, so a new request is accepted the cycle after the response handshake at earliest.
REQ-018 Latency: RspVld_SO rises shift+4 cycles after the accept cycle (accept = cycle 0).
REQ-019 Signed overflow (MIN / -1) SHALL pass through the divider unmodified.
REQ-020 ReqVld_SI outside IDLE SHALL be ignored; no queueing.

Reset
REQ-021 On Rst_RI: state IDLE, RspVld_SO=0, RspRes_DO=0, DivInVld_SO=0, DivOutRdy_SO=0, all DivOp* registers 0, Busy_SO=0; ReqRdy_SO=1 the first cycle after reset.
REQ-022 Reset mid-operation SHALL abort without a response; the integration drives the divider reset as the inverse of Rst_RI so both ends restart together.

Configuration
REQ-023 Macro RISCV_DIV_FASTZERO_EN defined: B==0 bypasses the divider; IDLE goes directly to RESP; result = all ones for udiv/div, A for urem/rem; RspVld_SO one cycle after accept; Div* signals stay idle.
REQ-024 Macro undefined: B==0 SHALL take the normal ISSUE/WAIT path with shift=C_WIDTH.

Structure
REQ-025 Package riscv_div_pkg SHALL hold opcode localparams (UDIV, DIV, UREM, REM) and FSM state encodings.
REQ-026 Sub-module riscv_div_lzc SHALL count leading zeros of a C_WIDTH vector, output C_LOG_WIDTH wide, all-zero input giving C_WIDTH; leading ones are obtained by inverting the input.

Verification
REQ-027 udiv 100/7 (shift 29) -> RspRes_DO=14, RspVld_SO 33 cycles after accept.
REQ-028 rem 0xFFFFFFF9 / 2 -> RspRes_DO=0xFFFFFFFF; div 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
REQ-029 udiv 5/0 and urem 5/0 -> 0xFFFFFFFF and 5; with macro RspVld_SO 1 cycle after accept and DivInVld_SO never high.
REQ-030 RspRdy_SI held low 10 cycles in RESP -> RspVld_SO and RspRes_DO stable, ReqRdy_SO=0; ReqRdy_SO=1 the cycle after the handshake.
REQ-031 Rst_RI pulsed during WAIT -> next cycle all outputs at reset values, no RspVld_SO, next request completes normally.
REQ-032 div 0x80000000 / 0xFFFFFFFF -> RspRes_DO=0x80000000.
